// File: rtl/psum_accum_pkg.sv
// psum_accum_pkg -- shared types and constants for the partial-sum accumulator.
//   state_t   : accumulator FSM states
//   ptr_w()   : pointer width for a given entry count ($clog2(DEPTH), minimum 1)
//   lane_max()/lane_min() : saturation limits of a signed lane of a given width
//   DEF_*     : default geometry and matching default limits
package psum_accum_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACC   = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Pointer width needed to address 'depth' entries.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Largest / smallest value of a signed lane 'bw' bits wide.
  function automatic logic signed [63:0] lane_max(input int bw);
    return (64'sd1 <<< (bw - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] lane_min(input int bw);
    return -(64'sd1 <<< (bw - 1));
  endfunction

  localparam int DEF_COL     = 8;
  localparam int DEF_PSUM_BW = 16;
  localparam int DEF_DEPTH   = 16;
  localparam int DEF_PTR_W   = $clog2(DEF_DEPTH);
  localparam logic signed [DEF_PSUM_BW-1:0] DEF_LANE_MAX = 16'sh7FFF;
  localparam logic signed [DEF_PSUM_BW-1:0] DEF_LANE_MIN = 16'sh8000;

endpackage

// File: rtl/psum_sat_add.sv
// psum_sat_add -- one signed saturating lane adder.
//   a, b : signed BW-bit operands
//   sum  : a + b clamped to [-2^(BW-1), 2^(BW-1)-1]
module psum_sat_add
  import psum_accum_pkg::*;
#(
  parameter int BW = DEF_PSUM_BW
) (
  input  logic signed [BW-1:0] a,
  input  logic signed [BW-1:0] b,
  output logic signed [BW-1:0] sum
);

  localparam logic signed [63:0] MAX64 = lane_max(BW);
  localparam logic signed [63:0] MIN64 = lane_min(BW);
  localparam logic signed [BW-1:0] MAXV = MAX64[BW-1:0];
  localparam logic signed [BW-1:0] MINV = MIN64[BW-1:0];

  logic signed [BW:0] full;

  // One extra bit holds the exact sum; overflow shows as the top two bits differing.
  assign full = {a[BW-1], a} + {b[BW-1], b};

  always_comb begin
    sum = full[BW-1:0];
    if (full[BW] != full[BW-1]) begin
      sum = full[BW] ? MINV : MAXV;
    end
  end

endmodule

// File: rtl/psum_accum.sv
// psum_accum -- multi-pass partial-sum accumulator with drain port.
// Reads DEPTH*npass vectors from an upstream FIFO, accumulates them per entry
// (pass 0 overwrites, later passes saturating-add), then drains the DEPTH
// entries through a valid/ready port and pulses o_done.
// Optional build macro: PSUM_RELU_EN -- negative drained lanes output as 0.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   start, i_npass    : begin a tile (IDLE only); passes per tile (0 means 1)
//   i_empty, o_rd     : upstream FIFO empty flag / read strobe
//   i_data            : upstream data, returned one cycle after o_rd
//   o_data, o_valid   : drained vector and its valid
//   i_ready           : downstream accept
//   o_busy, o_done    : not-idle flag, one-cycle end-of-tile pulse
module psum_accum
  import psum_accum_pkg::*;
#(
  parameter int COL     = DEF_COL,
  parameter int PSUM_BW = DEF_PSUM_BW,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             i_npass,
  input  logic                   i_empty,
  output logic                   o_rd,
  input  logic [COL*PSUM_BW-1:0] i_data,
  output logic [COL*PSUM_BW-1:0] o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int VEC_W = COL * PSUM_BW;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  state_t state_reg, state_next;

  logic [PTR_W-1:0] rptr_reg, rptr_d1_reg, dptr_reg;
  logic [3:0]       pass_reg, pass_d1_reg, npass_reg;
  logic             rd_d1_reg;

  logic [VEC_W-1:0] mem [DEPTH];
  logic [VEC_W-1:0] mem_q_reg;

  logic             last_read;
  logic             xfer;
  logic [PTR_W-1:0] dptr_inc;
  logic [PTR_W-1:0] rd_addr;
  logic [VEC_W-1:0] sum_vec;
  logic [VEC_W-1:0] wr_data;
  logic [VEC_W-1:0] drain_vec;

  assign last_read = o_rd && (rptr_reg == LAST_PTR) && (pass_reg == npass_reg - 4'd1);
  assign xfer      = (state_reg == ST_DRAIN) && i_ready;
  assign dptr_inc  = (dptr_reg == LAST_PTR) ? '0 : dptr_reg + 1'b1;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    o_rd       = 1'b0;
    o_valid    = 1'b0;
    o_busy     = 1'b1;
    o_done     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (start) state_next = ST_ACC;
      end
      ST_ACC: begin
        o_rd = !i_empty;
        if (last_read) state_next = ST_FLUSH;
      end
      // Final read's data arrives here and is written; nothing else to do.
      ST_FLUSH: state_next = ST_DRAIN;
      ST_DRAIN: begin
        o_valid = 1'b1;
        if (xfer && dptr_reg == LAST_PTR) state_next = ST_DONE;
      end
      ST_DONE: begin
        o_done     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------- pointers and counters ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr_reg    <= '0;
      rptr_d1_reg <= '0;
      dptr_reg    <= '0;
      pass_reg    <= '0;
      pass_d1_reg <= '0;
      npass_reg   <= 4'd1;
      rd_d1_reg   <= 1'b0;
    end else begin
      rd_d1_reg   <= o_rd;
      rptr_d1_reg <= rptr_reg;
      pass_d1_reg <= pass_reg;
      if (state_reg == ST_IDLE && start) begin
        rptr_reg  <= '0;
        pass_reg  <= '0;
        dptr_reg  <= '0;
        npass_reg <= (i_npass == 4'd0) ? 4'd1 : i_npass;
      end
      if (o_rd) begin
        if (rptr_reg == LAST_PTR) begin
          rptr_reg <= '0;
          pass_reg <= pass_reg + 4'd1;
        end else begin
          rptr_reg <= rptr_reg + 1'b1;
        end
      end
      if (xfer) dptr_reg <= dptr_inc;
    end
  end

  // ---------------- accumulator storage ----------------
  // Single registered read port shared by accumulate and drain. During ACC it
  // tracks rptr so the old entry is ready when the read data returns; during
  // FLUSH it preloads entry 0 and during DRAIN it looks one transfer ahead so
  // o_data is always the current dptr entry.
  always_comb begin
    rd_addr = '0;
    if (state_reg == ST_ACC)        rd_addr = rptr_reg;
    else if (state_reg == ST_DRAIN) rd_addr = xfer ? dptr_inc : dptr_reg;
  end

  for (genvar gi = 0; gi < COL; gi++) begin : g_lane
    psum_sat_add #(.BW(PSUM_BW)) u_add (
      .a   (mem_q_reg[gi*PSUM_BW +: PSUM_BW]),
      .b   (i_data[gi*PSUM_BW +: PSUM_BW]),
      .sum (sum_vec[gi*PSUM_BW +: PSUM_BW])
    );

`ifdef PSUM_RELU_EN
    assign drain_vec[gi*PSUM_BW +: PSUM_BW] =
      mem_q_reg[(gi+1)*PSUM_BW-1] ? '0 : mem_q_reg[gi*PSUM_BW +: PSUM_BW];
`else
    assign drain_vec[gi*PSUM_BW +: PSUM_BW] = mem_q_reg[gi*PSUM_BW +: PSUM_BW];
`endif
  end

  assign wr_data = (pass_d1_reg == 4'd0) ? i_data : sum_vec;

  // Entries are deliberately unreset: pass 0 always overwrites before use.
  // A read hitting the entry being written this cycle takes the new value.
  always_ff @(posedge clk) begin
    if (rd_d1_reg) mem[rptr_d1_reg] <= wr_data;
    if (rd_d1_reg && rptr_d1_reg == rd_addr) mem_q_reg <= wr_data;
    else                                     mem_q_reg <= mem[rd_addr];
  end

  assign o_data = (state_reg == ST_DRAIN) ? drain_vec : '0;

endmodule

// File: tb/tb_psum_accum.sv
module tb_psum_accum;
  localparam int COL   = 8;
  localparam int BW    = 16;
  localparam int DEPTH = 4;
  localparam int VW    = COL * BW;
  typedef logic [VW-1:0] vec_t;

  logic       clk = 1'b0;
  logic       reset, start, i_empty, o_rd, o_valid, i_ready, o_busy, o_done;
  logic [3:0] i_npass;
  vec_t       i_data, o_data;

  always #5 clk = ~clk;

  psum_accum #(.COL(COL), .PSUM_BW(BW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .i_npass (i_npass),
    .i_empty (i_empty),
    .o_rd    (o_rd),
    .i_data  (i_data),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_busy  (o_busy),
    .o_done  (o_done)
  );

  int   n_vec = 0, n_miss = 0;
  vec_t up_q[$], exp_q[$], tile_vecs[$];
  bit   toggle_en = 0, phase = 0, rd_pend = 0;
  vec_t rd_stash;
  int   done_cnt = 0, rd_cnt = 0, xfer_idx = 0, stall_left = 0;

  task automatic chk(input string tag, input vec_t got, input vec_t exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic vec_t vec_all(input logic [BW-1:0] v);
    return {COL{v}};
  endfunction

  function automatic int clamp(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Upstream FIFO model and drain monitor; inputs change on the falling edge,
  // outputs are sampled 1 time unit later.
  initial begin
    i_data  = '0;
    i_empty = 1'b1;
    i_ready = 1'b1;
    forever begin
      @(negedge clk);
      i_data  = rd_pend ? rd_stash : {COL{16'hDEAD}};
      rd_pend = 0;
      phase   = ~phase;
      i_empty = (up_q.size() == 0) || (toggle_en && phase);
      i_ready = !(stall_left > 0 && xfer_idx == 1);
      #1;
      if (!reset) begin
        if (i_empty && o_busy) chk("rd_when_empty", vec_t'(o_rd), '0);
        if (o_rd) begin
          if (up_q.size() == 0) chk("rd_underflow", vec_t'(1), '0);
          else begin
            rd_stash = up_q.pop_front();
            rd_pend  = 1;
            rd_cnt++;
          end
        end
        if (o_valid && !i_ready) begin
          stall_left--;
          if (exp_q.size() > 0) chk("hold", o_data, exp_q[0]);
        end
        if (o_valid && i_ready) begin
          if (exp_q.size() == 0) chk("extra_vec", vec_t'(1), '0);
          else chk("drain", o_data, exp_q.pop_front());
          xfer_idx++;
        end
        if (o_done) begin
          done_cnt++;
          chk("done_after_last", vec_t'(exp_q.size()), '0);
        end
      end
    end
  end

  // Compute expected drain vectors for tile_vecs, hand data upstream, run tile.
  task automatic run_tile(input logic [3:0] np, input bit extra_start);
    int   eff;
    int   dc0;
    bit   seen;
    vec_t r, v;
    logic signed [BW-1:0] x;
    int   acc;
    eff = (np == 0) ? 1 : int'(np);
    for (int e = 0; e < DEPTH; e++) begin
      r = '0;
      for (int l = 0; l < COL; l++) begin
        v   = tile_vecs[e];
        x   = v[l*BW +: BW];
        acc = int'(x);
        for (int p = 1; p < eff; p++) begin
          v   = tile_vecs[p*DEPTH + e];
          x   = v[l*BW +: BW];
          acc = clamp(acc + int'(x));
        end
`ifdef PSUM_RELU_EN
        if (acc < 0) acc = 0;
`endif
        r[l*BW +: BW] = acc[BW-1:0];
      end
      exp_q.push_back(r);
    end
    foreach (tile_vecs[i]) up_q.push_back(tile_vecs[i]);
    xfer_idx = 0;
    dc0      = done_cnt;
    @(negedge clk);
    i_npass = np;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    i_npass = 4'hF;   // must not be resampled mid-tile
    seen = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      start = (extra_start && c == 3);
      if (done_cnt != dc0) begin
        seen = 1;
        break;
      end
    end
    start = 1'b0;
    chk("done_seen", vec_t'(seen), vec_t'(1));
    repeat (3) @(negedge clk);
    chk("done_pulses", vec_t'(done_cnt - dc0), vec_t'(1));
    chk("idle_after", vec_t'(o_busy), '0);
    chk("left_over", vec_t'(exp_q.size()), '0);
    tile_vecs.delete();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_o_rd", vec_t'(o_rd), '0);
    chk("rst_o_valid", vec_t'(o_valid), '0);
    chk("rst_o_busy", vec_t'(o_busy), '0);
    chk("rst_o_done", vec_t'(o_done), '0);
    chk("rst_o_data", o_data, '0);
  endtask

  initial begin
    vec_t v;
    int   r0;
    reset   = 1'b1;
    start   = 1'b0;
    i_npass = 4'd1;
    repeat (3) @(negedge clk);
    #2;
    chk_reset_outputs();
    @(negedge clk);
    reset = 1'b0;

    // npass=1 ramp 10..13
    for (int k = 0; k < DEPTH; k++) tile_vecs.push_back(vec_all(16'(10 + k)));
    run_tile(4'd1, 0);

    // positive and negative saturation over 3 passes
    for (int k = 0; k < 3*DEPTH; k++) tile_vecs.push_back(vec_all(16'h7000));
    run_tile(4'd3, 0);
    for (int k = 0; k < 3*DEPTH; k++) tile_vecs.push_back(vec_all(16'h9000));
    run_tile(4'd3, 0);

    // empty toggling, plus a stray start mid-tile
    toggle_en = 1;
    for (int k = 0; k < DEPTH; k++) tile_vecs.push_back(vec_all(16'(10 + k)));
    run_tile(4'd1, 1);
    toggle_en = 0;

    // downstream stall of 3 cycles at dptr=1
    stall_left = 3;
    for (int k = 0; k < DEPTH; k++) tile_vecs.push_back(vec_all(16'(10 + k)));
    run_tile(4'd1, 0);
    chk("stall_consumed", vec_t'(stall_left), '0);
    stall_left = 0;

    // random lanes, 2 passes, and npass=0 behaving as 1
    for (int k = 0; k < 2*DEPTH; k++) begin
      for (int l = 0; l < COL; l++) v[l*BW +: BW] = 16'($urandom);
      tile_vecs.push_back(v);
    end
    run_tile(4'd2, 0);
    for (int k = 0; k < DEPTH; k++) tile_vecs.push_back(vec_all(16'(300 + k)));
    run_tile(4'd0, 0);

    // reset mid-tile after 2 reads
    r0 = rd_cnt;
    for (int k = 0; k < DEPTH; k++) up_q.push_back(vec_all(16'(100 + k)));
    @(negedge clk);
    i_npass = 4'd1;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 50 && (rd_cnt - r0) < 2; c++) @(negedge clk);
    chk("two_reads", vec_t'(rd_cnt - r0 >= 2), vec_t'(1));
    reset = 1'b1;
    up_q.delete();
    exp_q.delete();
    #2;
    chk_reset_outputs();
    repeat (2) @(negedge clk);
    #2;
    chk_reset_outputs();
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < DEPTH; k++) tile_vecs.push_back(vec_all(16'(50 + k)));
    run_tile(4'd1, 0);

    // negative lane 0 (ReLU dependent)
    for (int k = 0; k < DEPTH; k++) begin
      v = vec_all(16'd7);
      v[BW-1:0] = 16'hFFEC;
      tile_vecs.push_back(v);
    end
    run_tile(4'd1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/psum_accum.md
PSUM_ACCUM -- requirements
Module: psum_accum

Interface
- REQ-001: Parameter COL, default 8, number of psum lanes per vector; matches the upstream output FIFO column count.
- REQ-002: Parameter PSUM_BW, default 16, signed two's-complement width of each lane.
- REQ-003: Parameter DEPTH, default 16, number of accumulator entries (output vectors per tile).
- REQ-004: Port clk, input, 1, single clock; all state updates on its rising edge.
- REQ-005: Port reset, input, 1, asynchronous active-high reset.
- REQ-006: Port start, input, 1, one-cycle pulse that begins a tile; honoured only in IDLE.
- REQ-007: Port i_npass, input, 4, accumulation passes per tile; sampled on accepted start; value 0 treated as 1.
- REQ-008: Port i_empty, input, 1, upstream FIFO empty flag.
- REQ-009: Port o_rd, output, 1, read strobe to upstream FIFO.
- REQ-010: Port i_data, input, COL*PSUM_BW, upstream read data, lane i at bits [(i+1)*PSUM_BW-1 : i*PSUM_BW].
- REQ-011: Port o_data, output, COL*PSUM_BW, drained accumulated vector, same lane packing.
- REQ-012: Port o_valid, output, 1, o_data valid.
- REQ-013: Port i_ready, input, 1, downstream accept; transfer when o_valid and i_ready are both high.
- REQ-014: Port o_busy, output, 1, high in every state except IDLE.
- REQ-015: Port o_done, output, 1, one-cycle pulse after the last vector is transferred.

Function
- REQ-016: FSM states IDLE, ACC, FLUSH, DRAIN, DONE; reset state IDLE.
- REQ-017: IDLE->ACC on start; clears the read pointer (rptr), pass counter and drain pointer (dptr).
- REQ-018: In ACC, o_rd = !i_empty; o_rd never asserts while i_empty is high or outside ACC.
- REQ-019: Each o_rd advances rptr by 1 and wraps DEPTH-1->0; the wrap increments the pass counter.
- REQ-020: Upstream returns i_data exactly one cycle after o_rd; the block captures it on that cycle into entry rptr_d1.
- REQ-021: Pass 0 writes i_data into the entry; later passes write the per-lane saturating sum entry+i_data.
- REQ-022: Saturation clamps each lane to [-2^(PSUM_BW-1), 2^(PSUM_BW-1)-1]; no wrap-around.
- REQ-023: ACC->FLUSH on the cycle issuing the DEPTH*npass-th read; FLUSH lasts one cycle (final write), then DRAIN.
- REQ-024: In DRAIN, o_valid=1 and o_data=entry dptr (post-processed per REQ-030); dptr advances only on transfer.
- REQ-025: o_data and o_valid hold stable while i_ready is low.
- REQ-026: Transfer at dptr=DEPTH-1 moves DRAIN->DONE; DONE asserts o_done for one cycle, then IDLE.
- REQ-027: start outside IDLE is ignored; i_npass is not resampled mid-tile.

Reset
- REQ-028: Asserting reset in any state, mid-tile included, immediately forces IDLE; o_rd, o_valid, o_busy and o_done go to 0, o_data to 0, and all pointers and counters to 0.
- REQ-029: Accumulator entries are not reset; pass 0 overwrites them before use.

Configuration
- REQ-030: Macro PSUM_RELU_EN defined: each drained lane that is negative outputs 0 (ReLU). Undefined: lanes output unchanged; no ReLU logic is synthesised.

Structure
- REQ-031: Package psum_accum_pkg holds the FSM state enum, the pointer-width constant $clog2(DEPTH) and the lane saturation limit constants.
- REQ-032: Sub-module psum_sat_add, one signed saturating lane adder, instantiated COL times.

Verification (COL=8, PSUM_BW=16, DEPTH=4)
- REQ-033: npass=1, vector k has all lanes = 10+k -> drained vectors 10,11,12,13 in order, then one o_done pulse.
- REQ-034: npass=3, every lane 0x7000 each pass -> all lanes drain 0x7FFF; with 0x9000 each pass -> all lanes drain 0x8000.
- REQ-035: i_empty toggles 1/0 every cycle during ACC -> o_rd never high while i_empty=1; results identical to REQ-033.
- REQ-036: i_ready held low 3 cycles at dptr=1 -> o_data stays vector 1 and o_valid stays high throughout; no vector lost or duplicated.
- REQ-037: reset asserted after 2 reads, then new start with npass=1 -> all outputs 0 during reset; next tile drains only new data.
- REQ-038: npass=1, lane 0 = -20 -> drains 0x0000 with PSUM_RELU_EN, 0xFFEC without.
